ram8_tester: RTL and testbench
==============================

RAM8_TESTER -- requirements
Module: ram8_tester

Interface
REQ-001 The block SHALL have one clock and one reset; reset SHALL be asynchronous and active-high.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  test request, sampled only in IDLE.
REQ-005 seed  input  16  pattern base, latched when start is accepted.
REQ-006 mem_out  input  16  RAM8 read data; combinational from mem_add, same cycle.
REQ-007 mem_in  output  16  RAM8 write data.
REQ-008 mem_add  output  3  RAM8 address.
REQ-009 mem_load  output  1  RAM8 write enable; the RAM8 captures mem_in at mem_add on the clk edge ending a cycle with mem_load=1.
REQ-010 busy  output  1  high in WRITE and READ states.
REQ-011 done  output  1  one-cycle pulse in the DONE state.
REQ-012 pass  output  1  1 when the last completed test had zero mismatches.
REQ-013 fail_add  output  3  address of the first mismatch in the last test; 0 if none.
REQ-014 err_count  output  4  mismatch count of the last test, range 0..8.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, WRITE, READ, DONE, plus a 3-bit address counter k.
REQ-016 IDLE with start=1 at an edge SHALL transition to WRITE with k=0; the same edge latches seed and clears pass, fail_add and err_count.
REQ-017 A start high in WRITE, READ or DONE SHALL be ignored; no queuing.
REQ-018 WRITE SHALL drive mem_add=k, mem_in=(seed+k) mod 2^16 and mem_load=1, and increment k at each edge.
REQ-019 WRITE with k=7 SHALL go to READ with k=0 (k wraps 7->0).
REQ-020 READ SHALL drive mem_add=k, mem_load=0 and mem_in=0, and compare mem_out against (seed+k) mod 2^16 at each edge.
REQ-021 On a READ mismatch err_count SHALL increment; fail_add SHALL capture k only on the first mismatch of the test.
REQ-022 READ with k=7 SHALL go to DONE, and the k=7 comparison SHALL be included in the result.
REQ-023 DONE SHALL last one cycle with done=1, set pass=(err_count==0) including the k=7 result, and then return to IDLE.
REQ-024 Latency SHALL be 8 WRITE cycles + 8 READ cycles: done is high in the 17th cycle after the start-accepting edge.
REQ-025 pass, fail_add and err_count SHALL hold from DONE until the next accepted start.
REQ-026 Outside WRITE: mem_load=0. Outside WRITE and READ: mem_add=0 and mem_in=0.
REQ-027 mem_load, mem_add and mem_in SHALL be decoded from registered state and k only, with no path from mem_out.
REQ-028 Pattern addition SHALL be 16-bit unsigned with wrap and no carry out, e.g. seed=0xFFFE, k=3 gives 0x0001.

Reset
REQ-029 On rst=1, asynchronously and without waiting for clk:
- state=IDLE, k=0
- busy=0, done=0, pass=0, fail_add=0, err_count=0
- mem_load=0, mem_add=0, mem_in=0
REQ-030 rst asserted mid-test SHALL abort the test with no partial result retained; RAM contents are then undefined for the next test.
REQ-031 After rst deasserts, the first rising edge with start=1 SHALL start a test normally.

Verification
REQ-032 Fault-free RAM8, seed=0x1234, start pulsed one cycle -> writes 0x1234..0x123B to addresses 0..7; done in cycle 17; pass=1, err_count=0, fail_add=0.
REQ-033 mem_out forced to 0x0000 whenever mem_add=5, seed=0x1234 -> pass=0, fail_add=5, err_count=1.
REQ-034 mem_out forced to 0xFFFF for all addresses, seed=0x0000 -> pass=0, fail_add=0, err_count=8 (no overflow).
REQ-035 seed=0xFFFC -> address 4..7 expected values 0x0000..0x0003; pass=1 on fault-free RAM8.
REQ-036 start held high for 20 cycles from IDLE -> exactly one test; done pulses once in cycle 17; a second test starts only from IDLE.
REQ-037 rst pulsed while the FSM is in WRITE with k=3 -> mem_load=0 and busy=0 before the next clk edge; all outputs at reset values; a following start with seed=0x00AA completes with pass=1.

Source files
------------

// File: rtl/ram8_tester.sv
// Built-in self-test sequencer for an 8-word x 16-bit RAM: writes seed+k to every address,
// reads each word back, and reports pass, first failing address and mismatch count.
module ram8_tester (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] seed,
  input  logic [15:0] mem_out,
  output logic [15:0] mem_in,
  output logic [2:0]  mem_add,
  output logic        mem_load,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [2:0]  fail_add,
  output logic [3:0]  err_count
);

  typedef enum logic [1:0] {StIdle, StWrite, StRead, StDone} state_e;

  state_e      r_state;
  state_e      w_state_next;
  logic [2:0]  r_k;
  logic [2:0]  w_k_next;
  logic [15:0] r_seed;
  logic        r_pass;
  logic [2:0]  r_fail_add;
  logic [3:0]  r_err_count;
  logic [15:0] w_expect;
  logic        w_accept;
  logic        w_mismatch;

  assign w_expect   = r_seed + {13'd0, r_k};
  assign w_accept   = (r_state == StIdle) && start;
  assign w_mismatch = (r_state == StRead) && (mem_out != w_expect);

  always_comb begin
    w_state_next = r_state;
    w_k_next     = r_k;
    mem_in       = 16'd0;
    mem_add      = 3'd0;
    mem_load     = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_state_next = StWrite;
          w_k_next     = 3'd0;
        end
      end
      StWrite: begin
        busy     = 1'b1;
        mem_load = 1'b1;
        mem_add  = r_k;
        mem_in   = w_expect;
        w_k_next = r_k + 3'd1;
        if (r_k == 3'd7) w_state_next = StRead;
      end
      StRead: begin
        busy     = 1'b1;
        mem_add  = r_k;
        w_k_next = r_k + 3'd1;
        if (r_k == 3'd7) w_state_next = StDone;
      end
      StDone: begin
        done         = 1'b1;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_k         <= 3'd0;
      r_seed      <= 16'd0;
      r_pass      <= 1'b0;
      r_fail_add  <= 3'd0;
      r_err_count <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_k     <= w_k_next;
      if (w_accept) begin
        r_seed      <= seed;
        r_pass      <= 1'b0;
        r_fail_add  <= 3'd0;
        r_err_count <= 4'd0;
      end else if (w_mismatch) begin
        r_err_count <= r_err_count + 4'd1;
        if (r_err_count == 4'd0) r_fail_add <= r_k;
      end
      // err_count already includes the k=7 comparison once DONE is reached
      if (r_state == StDone) r_pass <= (r_err_count == 4'd0);
    end
  end

  assign pass      = r_pass;
  assign fail_add  = r_fail_add;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_ram8_tester.sv
// Directed bench for ram8_tester with a behavioural RAM8 and selectable read-data faults.
module tb_ram8_tester;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] seed;
  logic [15:0] mem_out;
  logic [15:0] mem_in;
  logic [2:0]  mem_add;
  logic        mem_load;
  logic        busy;
  logic        done;
  logic        pass;
  logic [2:0]  fail_add;
  logic [3:0]  err_count;

  int checks = 0;
  int errors = 0;
  int fault_mode = 0;

  logic [15:0] ram [8];

  ram8_tester dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .seed     (seed),
    .mem_out  (mem_out),
    .mem_in   (mem_in),
    .mem_add  (mem_add),
    .mem_load (mem_load),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .fail_add (fail_add),
    .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (mem_load) ram[mem_add] <= mem_in;

  // 1: addr 5 reads 0; 2: every read is 0xFFFF; 3: addr 2 and 6 read with bit 8 flipped
  always_comb begin
    mem_out = ram[mem_add];
    case (fault_mode)
      1: if (mem_add == 3'd5) mem_out = 16'h0000;
      2: mem_out = 16'hFFFF;
      3: if (mem_add == 3'd2 || mem_add == 3'd6) mem_out = ram[mem_add] ^ 16'h0100;
      default: ;
    endcase
  end

  typedef struct {
    logic [15:0] seed;
    int          fault;
    logic        pass;
    logic [2:0]  fadd;
    logic [3:0]  errc;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Starts a test and checks every output cycle by cycle through cycle 18 (back in IDLE).
  task automatic run_cycles(input logic [15:0] s, input int hold);
    logic [15:0] e_in;
    logic [2:0]  e_add;
    @(negedge clk);
    seed  = s;
    start = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 18; cyc++) begin
      @(negedge clk);
      if (cyc >= hold) start = 1'b0;
      e_in  = (cyc <= 8) ? s + 16'(cyc - 1) : 16'd0;
      e_add = (cyc <= 8) ? 3'(cyc - 1) : (cyc <= 16) ? 3'(cyc - 9) : 3'd0;
      check($sformatf("cycle%0d busy/load/add/in/done", cyc),
            {40'd0, busy, mem_load, mem_add, mem_in, done},
            {40'd0, 1'(cyc <= 16), 1'(cyc <= 8), e_add, e_in, 1'(cyc == 17)});
      if (cyc <= 8) check($sformatf("cycle%0d results cleared", cyc),
                          {56'd0, pass, fail_add, err_count}, 64'd0);
    end
  endtask

  task automatic run_vector(input vec_t v, input string tag);
    fault_mode = v.fault;
    run_cycles(v.seed, 1);
    check({tag, " result"}, {56'd0, pass, fail_add, err_count}, {56'd0, v.pass, v.fadd, v.errc});
    repeat (3) @(negedge clk);
    check({tag, " result held"}, {56'd0, pass, fail_add, err_count},
          {56'd0, v.pass, v.fadd, v.errc});
    for (int i = 0; i < 8; i++)
      check($sformatf("%s ram[%0d]", tag, i), {48'd0, ram[i]}, {48'd0, v.seed + 16'(i)});
  endtask

  initial begin
    vecs[0] = '{seed: 16'h1234, fault: 0, pass: 1'b1, fadd: 3'd0, errc: 4'd0};
    vecs[1] = '{seed: 16'h1234, fault: 1, pass: 1'b0, fadd: 3'd5, errc: 4'd1};
    vecs[2] = '{seed: 16'h0000, fault: 2, pass: 1'b0, fadd: 3'd0, errc: 4'd8};
    vecs[3] = '{seed: 16'hFFFC, fault: 0, pass: 1'b1, fadd: 3'd0, errc: 4'd0};
    vecs[4] = '{seed: 16'h0050, fault: 3, pass: 1'b0, fadd: 3'd2, errc: 4'd2};

    rst   = 1'b1;
    start = 1'b0;
    seed  = 16'd0;
    #2;
    check("reset outputs", {24'd0, busy, done, pass, fail_add, err_count, mem_load, mem_add, mem_in},
          64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) run_vector(vecs[i], $sformatf("vec%0d", i));

    // Start held high: one test, then a fresh one only after returning to IDLE.
    fault_mode = 0;
    run_cycles(16'h0777, 20);
    check("held start pass", {63'd0, pass}, 64'd1);
    @(negedge clk);
    check("held start restarts from idle", {63'd0, busy}, 64'd1);
    start = 1'b0;
    begin
      int n = 0;
      while (!done && n < 30) begin
        @(negedge clk);
        n++;
      end
      check("second test done within bound", {63'd0, done}, 64'd1);
    end
    @(negedge clk);

    // Reset in WRITE with k=3 aborts immediately, before any clock edge.
    seed  = 16'h5555;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("write k=3 before reset", {60'd0, mem_load, mem_add}, {60'd0, 1'b1, 3'd3});
    #1 rst = 1'b1;
    #1;
    check("async reset outputs",
          {24'd0, busy, done, pass, fail_add, err_count, mem_load, mem_add, mem_in}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_vector('{seed: 16'h00AA, fault: 0, pass: 1'b1, fadd: 3'd0, errc: 4'd0}, "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 200000");
    $fatal(1);
  end

endmodule
